// File: rtl/uart_pkg.sv
// Shared encodings for the UART transmit path: FSM states and tx line mux selects.
// The serializer and the output mux decode the same select codes.
package uart_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam logic [1:0] MUX_START = 2'd0;
    localparam logic [1:0] MUX_STOP  = 2'd1;
    localparam logic [1:0] MUX_DATA  = 2'd2;
    localparam logic [1:0] MUX_PAR   = 2'd3;

    // Line select that goes with each state; idle and stop both hold the line high.
    function automatic logic [1:0] state_mux(input logic [2:0] s);
        case (s)
            START:   return MUX_START;
            DATA:    return MUX_DATA;
            PARITY:  return MUX_PAR;
            default: return MUX_STOP;
        endcase
    endfunction

endpackage

// File: rtl/uart_parity_calc.sv
// Parity of a payload word: even parity is the XOR reduction, odd parity inverts it.
module uart_parity_calc #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_type,
    output logic                  par_bit
);

    assign par_bit = (^data) ^ par_type;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: START -> DATA -> [PARITY] -> STOP, one state per tick.
// Outputs are registered from the next state, so they line up with the state they describe.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_valid,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  par_en,
    input  logic                  par_type,
    output logic                  ser_load,
    output logic                  ser_en,
    output logic [1:0]            mux_sel,
    output logic                  par_bit,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

    logic [2:0]            state;
    logic [2:0]            next_state;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] data_reg;
    logic [DATA_WIDTH-1:0] data_next;
    logic                  par_en_reg;
    logic                  par_type_reg;
    logic                  par_type_next;
    logic                  par_next;
    logic                  capture;

    // A new byte is only accepted between frames or in STOP (back-to-back).
    assign capture       = data_valid && ((state == IDLE) || (state == STOP));
    assign data_next     = capture ? p_data   : data_reg;
    assign par_type_next = capture ? par_type : par_type_reg;

    // Parity is computed from the value being captured, so par_bit is valid from START on.
    uart_parity_calc #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_parity (
        .data     (data_next),
        .par_type (par_type_next),
        .par_bit  (par_next)
    );

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves next_state unassigned (latch).
        next_state = state;
        case (state)
            IDLE:    if (data_valid) next_state = START;
            START:   next_state = DATA;
            DATA:    if (bit_cnt == CNT_W'(DATA_WIDTH - 1))
                         next_state = par_en_reg ? PARITY : STOP;
            PARITY:  next_state = STOP;
            STOP:    next_state = data_valid ? START : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state        <= IDLE;
            bit_cnt      <= '0;
            data_reg     <= '0;
            par_en_reg   <= 1'b0;
            par_type_reg <= 1'b0;
            ser_load     <= 1'b0;
            ser_en       <= 1'b0;
            mux_sel      <= MUX_STOP;
            par_bit      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state <= next_state;
            if (capture) begin
                data_reg     <= p_data;
                par_en_reg   <= par_en;
                par_type_reg <= par_type;
            end
            // Counter clears on entry to DATA and only advances while staying in DATA.
            if (next_state == DATA)
                bit_cnt <= (state == DATA) ? bit_cnt + CNT_W'(1) : '0;
            par_bit  <= par_next;
            ser_load <= (next_state == START);
            ser_en   <= (next_state == DATA);
            mux_sel  <= state_mux(next_state);
            busy     <= (next_state != IDLE);
        end
    end

endmodule
